// File: rtl/clk_en_pkg.sv
// Shared types and constants for the clock-enable generator.
package clk_en_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_en_cnt.sv
// Period counter: shadow-loads the effective period on start and on every wrap,
// counts 0..period-1 while busy and sits at 0 otherwise.
module clk_en_cnt
  import clk_en_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             busy,
  input  logic             load,
  input  logic [CNT_W-1:0] div,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] period,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_DIV);

  function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] d);
    return (d < MIN_P) ? MIN_P : d;
  endfunction

  assign wrap = busy && (cnt == period - 1'b1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      period <= MIN_P;
    end else if (load) begin
      cnt    <= '0;
      period <= eff_div(div);
    end else if (wrap) begin
      // A new div only takes hold at a period boundary.
      cnt    <= '0;
      period <= eff_div(div);
    end else if (busy) begin
      cnt    <= cnt + 1'b1;
    end else begin
      cnt    <= '0;
    end
  end

endmodule

// File: rtl/clk_en_gen.sv
// Clock-enable generator: one ce strobe per period, a derived data-level clock
// with edge pulses, and a data bit captured on each enable.
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] div,
  input  logic             din,
  output logic             ce,
  output logic             dclk,
  output logic             rise,
  output logic             fall,
  output logic             dout,
  output logic             busy
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  logic             wrap;
  logic             load;
  logic             dclk_q;
  logic             dout_q;

  // stop has priority over start when both are seen in IDLE.
  assign load = (state == IDLE) && start && !stop;

  clk_en_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .busy   (busy),
    .load   (load),
    .div    (div),
    .cnt    (cnt),
    .period (period),
    .wrap   (wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:     if (load) state <= RUN;
        // A stop seen on the wrap edge ends the run right there.
        RUN:      if (stop) state <= wrap ? IDLE : STOPPING;
        STOPPING: if (wrap) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign ce   = busy && (cnt == '0);
  assign dclk = busy && (cnt < (period >> 1));
  assign rise = dclk && !dclk_q;
  assign fall = !dclk && dclk_q;
  assign dout = dout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dclk_q <= 1'b0;
      dout_q <= 1'b0;
    end else begin
      dclk_q <= dclk;
      if (ce) dout_q <= din;
    end
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen; outputs are compared as {busy,ce,dclk,rise,fall,dout}.
module tb_clk_en_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [7:0] div;
  logic       din;
  logic       ce, dclk, rise, fall, dout, busy;

  int errors = 0;
  int checks = 0;

  clk_en_gen #(.CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .div   (div),
    .din   (din),
    .ce    (ce),
    .dclk  (dclk),
    .rise  (rise),
    .fall  (fall),
    .dout  (dout),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {busy, ce, dclk, rise, fall, dout};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and compare on the following falling edge.
  task automatic cyc(input string tag, input logic [5:0] exp);
    @(negedge clk);
    chk(tag, exp);
  endtask

  logic       din_t [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [5:0] exp_t [10] = '{6'b111100, 6'b101001, 6'b100011, 6'b100001,
                             6'b111101, 6'b101000, 6'b100010, 6'b100000,
                             6'b111100, 6'b101001};

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; div = 8'd4; din = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset", 6'b000000);

    // div=4: ce every 4, dclk 1100, then div 4->6 at cnt==1
    rst_n = 1'b1; start = 1'b1;
    cyc("d4_c0", 6'b111100);
    start = 1'b0;
    cyc("d4_c1", 6'b101000);
    cyc("d4_c2", 6'b100010);
    cyc("d4_c3", 6'b100000);
    cyc("d4_p2c0", 6'b111100);
    cyc("d4_p2c1", 6'b101000);
    div = 8'd6;
    cyc("d6chg_c2", 6'b100010);
    cyc("d6chg_c3", 6'b100000);
    cyc("d6_c0", 6'b111100);
    div = 8'd5;
    cyc("d6_c1", 6'b101000);
    cyc("d6_c2", 6'b101000);
    cyc("d6_c3", 6'b100010);
    cyc("d6_c4", 6'b100000);
    cyc("d6_c5", 6'b100000);
    cyc("d5_c0", 6'b111100);
    cyc("d5_c1", 6'b101000);

    // stop at cnt==1 with period 5; start while STOPPING ignored
    stop = 1'b1;
    cyc("stp_c2", 6'b100010);
    stop = 1'b0; start = 1'b1;
    cyc("stp_c3", 6'b100000);
    cyc("stp_c4", 6'b100000);
    cyc("stp_idle", 6'b000000);
    start = 1'b0;
    cyc("stp_idle2", 6'b000000);
    start = 1'b1; stop = 1'b1;
    cyc("both_idle", 6'b000000);
    cyc("both_idle2", 6'b000000);
    start = 1'b0; stop = 1'b0;

    // div=3: dclk 100
    div = 8'd3; start = 1'b1;
    cyc("d3_c0", 6'b111100);
    start = 1'b0;
    cyc("d3_c1", 6'b100010);
    cyc("d3_c2", 6'b100000);
    cyc("d3_p2c0", 6'b111100);
    stop = 1'b1;
    cyc("d3_stp_c1", 6'b100010);
    stop = 1'b0;
    cyc("d3_stp_c2", 6'b100000);
    cyc("d3_idle", 6'b000000);

    // div=0 and div=1 behave as 2
    div = 8'd0; start = 1'b1;
    cyc("d0_c0", 6'b111100);
    start = 1'b0;
    cyc("d0_c1", 6'b100010);
    cyc("d0_p2c0", 6'b111100);
    div = 8'd1;
    cyc("d0_p2c1", 6'b100010);
    cyc("d1_c0", 6'b111100);
    stop = 1'b1;
    cyc("d1_stp_c1", 6'b100010);
    stop = 1'b0;
    cyc("d1_idle", 6'b000000);

    // din capture on ce with div=4
    div = 8'd4; start = 1'b1;
    @(negedge clk);
    chk("cap_0", exp_t[0]);
    start = 1'b0;
    din = din_t[0];
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("cap_%0d", i), exp_t[i]);
      din = din_t[i];
    end

    // reset mid-period at cnt==2, start held through release
    cyc("pre_rst_c2", 6'b100011);
    rst_n = 1'b0; start = 1'b1;
    cyc("mid_rst", 6'b000000);
    cyc("mid_rst2", 6'b000000);
    rst_n = 1'b1;
    cyc("post_rst_c0", 6'b111100);
    start = 1'b0;
    cyc("post_rst_c1", 6'b101000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_en_gen.md
CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk sampled on rising edge; rst_n acts only at a clk rising edge.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the divide ratio and internal period counter.
REQ-003 Port clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the synchronous active-low reset.
REQ-005 Port start  input  1  SHALL be a level; sampled high in IDLE, it begins generation.
REQ-006 Port stop  input  1  SHALL be a level; sampled high in RUN, it requests a graceful stop.
REQ-007 Port div  input  CNT_W  SHALL be the requested period P in clk cycles.
REQ-008 Port din  input  1  SHALL be the data bit captured on each enable.
REQ-009 Port ce  output  1  SHALL be the one-cycle clock-enable strobe, once per period.
REQ-010 Port dclk  output  1  SHALL be the derived clock as a data-level signal, never used as a clock.
REQ-011 Port rise / fall  output  1 each  SHALL be one-cycle pulses marking dclk 0->1 / 1->0.
REQ-012 Port dout  output  1  SHALL hold the last din captured on ce.
REQ-013 Port busy  output  1  SHALL be high in RUN and STOPPING.

Function
REQ-014 States SHALL be IDLE, RUN and STOPPING; all outputs are Moore-decoded from registered state, counter cnt and registers dclk_q/dout_q.
REQ-015 Effective period SHALL be P_eff = max(div, 2); div of 0 or 1 is treated as 2.
REQ-016 P_eff SHALL be latched into a shadow register on entry to RUN and on every wrap (cnt==P_eff-1); div changes mid-period take effect only at the next period.
REQ-017 cnt SHALL count 0..P_eff-1 and wrap to 0 while busy; it is held at 0 in IDLE.
REQ-018 ce SHALL be high exactly in busy cycles where cnt==0.
REQ-019 dclk SHALL be high for cnt < P_eff/2 (integer floor) and low otherwise while busy; low in IDLE.
REQ-020 rise SHALL be high in the cycle dclk first reads 1 after reading 0; fall in the cycle dclk first reads 0 after 1.
REQ-021 IDLE->RUN SHALL occur when start=1 and stop=0; first ce is in the cycle immediately after the edge that sampled start.
REQ-022 start and stop high together in IDLE SHALL keep IDLE (stop wins).
REQ-023 start in RUN or STOPPING SHALL be ignored.
REQ-024 stop in RUN SHALL move to STOPPING; the current period completes; on the wrap edge state goes to IDLE, cnt to 0.
REQ-025 start while STOPPING SHALL be ignored; re-start requires IDLE.
REQ-026 On a ce cycle, dout SHALL take din at the next rising edge (one-cycle latency); otherwise dout holds, including in IDLE.

Reset
REQ-027 rst_n=0 at an edge SHALL force IDLE, cnt=0, shadow period=2, dclk=0, dout=0, ce=rise=fall=busy=0, regardless of state, including mid-period.
REQ-028 start held high through reset release SHALL enter RUN on the first edge with rst_n=1.

Structure
REQ-029 Package clk_en_pkg SHALL hold the state enum (IDLE, RUN, STOPPING) and constant MIN_DIV=2.
REQ-030 The period counter with shadow load and wrap detect SHALL be sub-module clk_en_cnt; FSM, dclk/edge logic and capture stay in clk_en_gen.

Verification
REQ-031 div=4, start pulse -> ce every 4 cycles, dclk 1,1,0,0 repeating, rise with first ce, fall 2 cycles later.
REQ-032 div=3 -> dclk 1,0,0 per period; div=0 and div=1 -> behave as div=2 (ce every 2 cycles, dclk alternating).
REQ-033 div changed 4->6 at cnt==1 -> current period stays 4 cycles; next ce-to-ce spacing 6.
REQ-034 stop at cnt==1 with div=5 -> busy drops after cnt==4 wrap; no extra ce; dclk low in IDLE; start+stop together in IDLE -> stays IDLE.
REQ-035 din toggled every cycle, div=4 -> dout equals din sampled in each ce cycle, updated one cycle later, stable between.
REQ-036 rst_n=0 at cnt==2 in RUN -> next cycle all outputs 0, IDLE; start after release -> first ce one cycle later.
